// File: rtl/drive_mode_arbiter_if.sv
// Interface bundling the requester inputs and the motor/servo outputs of
// drive_mode_arbiter. The master side is the upstream switch/beacon logic
// (and the testbench). The slave side is the arbiter itself.
interface drive_mode_arbiter_if;
    // Requests from switches, frequency detectors and comparators
    logic       manual_en;
    logic       track_en;
    logic [3:0] manual_dir;
    logic [2:0] manual_speed;
    logic [1:0] forward_signal;
    logic [1:0] left_signal;
    logic [1:0] right_signal;
    logic       fire_btn;
    logic       compA;
    logic       compB;
    // Commands to motor driver, PWM and servo controller
    logic [3:0] direction;
    logic [2:0] speed;
    logic       aiming;
    logic       fire_cmd;
    logic       fault;
    logic [2:0] mode;

    modport master (
        output manual_en, track_en, manual_dir, manual_speed,
               forward_signal, left_signal, right_signal,
               fire_btn, compA, compB,
        input  direction, speed, aiming, fire_cmd, fault, mode
    );

    modport slave (
        input  manual_en, track_en, manual_dir, manual_speed,
               forward_signal, left_signal, right_signal,
               fire_btn, compA, compB,
        output direction, speed, aiming, fire_cmd, fault, mode
    );
endinterface

// File: rtl/drive_mode_arbiter.sv
// drive_mode_arbiter: owns the single motor-driver/servo path and hands it
// to manual drive, beacon tracking or the aim/fire sequence. Overcurrent on
// compA/compB forces a timed FAULT stop that overrides every requester.
// Optional feature: define DRIVE_SOFT_START_EN to ramp the speed output one
// code per RAMP_CYCLES (direction reversals ramp through zero first).
// Without it, speed follows its target one cycle after the request.
module drive_mode_arbiter #(
    parameter int         OC_CYCLES   = 1000,
    parameter int         FAULT_HOLD  = 50_000_000,
    parameter int         AIM_CYCLES  = 100_000_000,
    parameter int         FIRE_CYCLES = 50_000_000,
    parameter int         LOST_CYCLES = 25_000_000,
    parameter logic [2:0] TRACK_SPEED = 3'd5,
    parameter int         RAMP_CYCLES = 1_000_000
) (
    input logic                 clock,
    input logic                 reset,
    drive_mode_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MANUAL = 3'd1,
        S_TRACK  = 3'd2,
        S_AIM    = 3'd3,
        S_FIRE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [3:0] DIR_STOP  = 4'b0000;
    localparam logic [3:0] DIR_FWD   = 4'b1010;
    localparam logic [3:0] DIR_REV   = 4'b0101;
    localparam logic [3:0] DIR_LEFT  = 4'b1001;
    localparam logic [3:0] DIR_RIGHT = 4'b0110;

    // One phase timer serves AIM, FIRE and FAULT, so it is sized for the longest.
    localparam int TMR_MAX =
        (AIM_CYCLES > FIRE_CYCLES)
            ? ((AIM_CYCLES  > FAULT_HOLD) ? AIM_CYCLES  : FAULT_HOLD)
            : ((FIRE_CYCLES > FAULT_HOLD) ? FIRE_CYCLES : FAULT_HOLD);
    localparam int TMR_W  = $clog2(TMR_MAX + 1);
    localparam int OC_W   = $clog2(OC_CYCLES + 1);
    localparam int LOST_W = $clog2(LOST_CYCLES + 1);

    state_t              state, state_nx;
    logic [TMR_W-1:0]    tmr;
    logic [OC_W-1:0]     oc_cnt;
    logic [LOST_W-1:0]   lost_cnt;
    logic                fire_s1, fire_s2, fire_s3;
    logic                fire_rise;
    logic                oc_in, oc_hit;
    logic                beacon, lost_hit;
    logic [3:0]          dir_tgt;
    logic [2:0]          spd_tgt;
    logic                aiming_nx, fire_nx, fault_nx;
    logic [3:0]          dir_q;
    logic [2:0]          spd_q;
    logic                aiming_q, fire_q, fault_q;

    // Unlisted manual direction codes are unsafe for the H-bridge: map to STOP.
    function automatic logic [3:0] decode_dir(input logic [3:0] code);
        case (code)
            DIR_FWD, DIR_REV, DIR_LEFT, DIR_RIGHT: return code;
            default:                               return DIR_STOP;
        endcase
    endfunction

    assign oc_in     = bus.compA | bus.compB;
    assign oc_hit    = oc_in && (oc_cnt >= OC_W'(OC_CYCLES - 1));
    assign fire_rise = fire_s2 & ~fire_s3;
    assign beacon    = (bus.forward_signal != 2'b00) || (bus.left_signal != 2'b00)
                    || (bus.right_signal != 2'b00);
    assign lost_hit  = (lost_cnt >= LOST_W'(LOST_CYCLES - 1));

    // Two-flop synchroniser for the button, plus a delayed copy for edge detect.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_s1 <= 1'b0;
            fire_s2 <= 1'b0;
            fire_s3 <= 1'b0;
        end else begin
            fire_s1 <= bus.fire_btn;
            fire_s2 <= fire_s1;
            fire_s3 <= fire_s2;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state selection; overcurrent entry is applied last so it wins.
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.manual_en)     state_nx = S_MANUAL;
                else if (bus.track_en) state_nx = S_TRACK;
            end
            S_MANUAL: begin
                if (!bus.manual_en) state_nx = S_IDLE;
            end
            S_TRACK: begin
                if (bus.manual_en)                                  state_nx = S_MANUAL;
                else if (!bus.track_en)                             state_nx = S_IDLE;
                else if (fire_rise && bus.forward_signal != 2'b00) state_nx = S_AIM;
            end
            S_AIM: begin
                if (tmr >= TMR_W'(AIM_CYCLES - 1)) state_nx = S_FIRE;
            end
            S_FIRE: begin
                if (tmr >= TMR_W'(FIRE_CYCLES - 1)) state_nx = S_TRACK;
            end
            S_FAULT: begin
                if (!oc_in && tmr >= TMR_W'(FAULT_HOLD - 1)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (oc_hit) state_nx = S_FAULT;
    end

    // Output targets for the state being entered, so outputs are one cycle behind inputs.
    always_comb begin
        dir_tgt   = DIR_STOP;
        spd_tgt   = 3'd0;
        aiming_nx = 1'b0;
        fire_nx   = 1'b0;
        fault_nx  = 1'b0;
        case (state_nx)
            S_MANUAL: begin
                dir_tgt = decode_dir(bus.manual_dir);
                spd_tgt = bus.manual_speed;
            end
            S_TRACK: begin
                spd_tgt = TRACK_SPEED;
                if (bus.forward_signal != 2'b00)    dir_tgt = DIR_FWD;
                else if (bus.left_signal != 2'b00)  dir_tgt = DIR_LEFT;
                else if (bus.right_signal != 2'b00) dir_tgt = DIR_RIGHT;
                else if (lost_hit)                  dir_tgt = DIR_RIGHT;
                else                                dir_tgt = dir_q;
            end
            S_AIM:   aiming_nx = 1'b1;
            S_FIRE: begin
                aiming_nx = 1'b1;
                fire_nx   = 1'b1;
            end
            S_FAULT: fault_nx = 1'b1;
            default: ;
        endcase
    end

    // Phase timer: restarts on every state change and while FAULT still sees overcurrent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmr <= '0;
        end else if (state_nx != state) begin
            tmr <= '0;
        end else if (state == S_FAULT && oc_in) begin
            tmr <= '0;
        end else if (state == S_AIM || state == S_FIRE || state == S_FAULT) begin
            tmr <= (tmr == TMR_W'(TMR_MAX)) ? tmr : tmr + 1'b1;
        end else begin
            tmr <= '0;
        end
    end

    // Overcurrent run-length and beacon-lost counters, both saturating.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oc_cnt   <= '0;
            lost_cnt <= '0;
        end else begin
            if (!oc_in)                            oc_cnt <= '0;
            else if (oc_cnt != OC_W'(OC_CYCLES))   oc_cnt <= oc_cnt + 1'b1;

            if (state != S_TRACK || state_nx != S_TRACK || beacon)
                lost_cnt <= '0;
            else if (lost_cnt != LOST_W'(LOST_CYCLES))
                lost_cnt <= lost_cnt + 1'b1;
        end
    end

    // Registered mode flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aiming_q <= 1'b0;
            fire_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            aiming_q <= aiming_nx;
            fire_q   <= fire_nx;
            fault_q  <= fault_nx;
        end
    end

`ifdef DRIVE_SOFT_START_EN
    localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);

    logic [RAMP_W-1:0] ramp_cnt;
    logic              dir_ok;
    logic [2:0]        step_tgt;

    // A new direction is only applied once the motor has ramped down to zero.
    always_comb begin
        dir_ok   = (dir_q == dir_tgt) || (spd_q == 3'd0);
        step_tgt = dir_ok ? spd_tgt : 3'd0;
    end

    // Speed ramp: one code per RAMP_CYCLES; a STOP target cuts speed at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_q    <= DIR_STOP;
            spd_q    <= 3'd0;
            ramp_cnt <= '0;
        end else if (dir_tgt == DIR_STOP) begin
            dir_q    <= DIR_STOP;
            spd_q    <= 3'd0;
            ramp_cnt <= '0;
        end else begin
            if (dir_ok) dir_q <= dir_tgt;
            if (spd_q == step_tgt) begin
                ramp_cnt <= '0;
            end else if (ramp_cnt >= RAMP_W'(RAMP_CYCLES - 1)) begin
                ramp_cnt <= '0;
                spd_q    <= (spd_q > step_tgt) ? spd_q - 3'd1 : spd_q + 3'd1;
            end else begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end
        end
    end
`else
    // Direction and speed follow their targets with one cycle of latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_q <= DIR_STOP;
            spd_q <= 3'd0;
        end else begin
            dir_q <= dir_tgt;
            spd_q <= spd_tgt;
        end
    end
`endif

    assign bus.direction = dir_q;
    assign bus.speed     = spd_q;
    assign bus.aiming    = aiming_q;
    assign bus.fire_cmd  = fire_q;
    assign bus.fault     = fault_q;
    assign bus.mode      = state;

endmodule
